// File: rtl/seq_array_multiplier_if.sv
// Handshake bundle for seq_array_multiplier: operand stream in, product stream out.
// The source side drives operands and accepts products (master); the multiplier is the slave.
interface seq_array_multiplier_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] z;
    logic               busy;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z, busy
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z, busy
    );
endinterface

// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add multiplier: one partial-product row per clock,
// WIDTH rows per product, valid/ready on both sides.
// Optional two's-complement operands: define SEQ_ARRAY_MULTIPLIER_SIGNED_EN.
module seq_array_multiplier #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_array_multiplier_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   z_q, z_d;

    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod;
    logic                 last_row;
    logic [WIDTH-1:0]     cap_mcand;
    logic [WIDTH-1:0]     cap_mplier;
    logic [2*WIDTH-1:0]   z_final;

    // The row counted as last is the one performed on the edge where cnt hits WIDTH-1.
    assign last_row = (cnt_q == CNT_W'(WIDTH - 1));

    // One row of the array: add the multiplicand if the current multiplier bit is set.
    // The carry lands in acc[WIDTH] and is shifted down, so it is never lost.
    assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
    assign sum    = acc_q + addend;

    // Product as it will stand after this edge's shift: {sum, mplier} >> 1, low 2*WIDTH bits.
    assign prod   = {sum, mplier_q[WIDTH-1:1]};

`ifdef SEQ_ARRAY_MULTIPLIER_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitudes feed the unsigned core; -2^(WIDTH-1) negates to itself, which
    // read as unsigned is exactly its magnitude.
    assign cap_mcand  = bus.x[WIDTH-1] ? -bus.x : bus.x;
    assign cap_mplier = bus.y[WIDTH-1] ? -bus.y : bus.y;
    assign z_final    = neg_q ? -prod : prod;

    // Result sign is latched at capture since x/y may change during RUN.
    always_ff @(posedge clk) begin
        if (rst) neg_q <= 1'b0;
        else     neg_q <= neg_d;
    end

    // Sign of the product, taken only when operands are accepted.
    always_comb begin
        neg_d = neg_q;
        if (state_q == IDLE && bus.in_valid)
            neg_d = bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
    end
`else
    assign cap_mcand  = bus.x;
    assign cap_mplier = bus.y;
    assign z_final    = prod;
`endif

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: accept in IDLE, run WIDTH rows, hold DONE until the consumer takes z.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_row)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath registers: operands, accumulator, row counter and held product.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            z_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            z_q      <= z_d;
        end
    end

    // Datapath next values: capture in IDLE, shift-add in RUN, everything held otherwise.
    // z only changes on the DONE entry edge so it keeps the last product afterwards.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        z_d      = z_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = cap_mcand;
                    mplier_d = cap_mplier;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = {1'b0, sum[WIDTH:1]};
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_row)
                    z_d = z_final;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.z         = z_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier: a WIDTH=4 and a WIDTH=8 instance on one clock.
// Expected values are hand-computed; the 4x4 sweep uses an array-style partial-product model.
module tb_seq_array_multiplier;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    seq_array_multiplier_if #(.WIDTH(4)) b4 ();
    seq_array_multiplier_if #(.WIDTH(8)) b8 ();

    seq_array_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    seq_array_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 4x4 array multiplier: sum of shifted partial-product rows.
    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
`ifdef SEQ_ARRAY_MULTIPLIER_SIGNED_EN
        logic signed [7:0] s;
        s = $signed(a) * $signed(b);
        p = s;
`else
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p + ({4'b0, a} << i);
`endif
        return p;
    endfunction

    // One transaction on the WIDTH=4 instance with out_ready=1.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] bb,
                        input logic [7:0] exp, input bit full);
        int n;
        if (full) check({tag, ".in_ready_idle"}, 32'(b4.in_ready), 32'd1);
        b4.in_valid = 1'b1;
        b4.x = a;
        b4.y = bb;
        step();
        b4.in_valid = 1'b0;
        b4.x = ~a;
        b4.y = ~bb;
        n = 0;
        while (!b4.out_valid && n < 20) begin
            if (full) check({tag, ".in_ready_run"}, 32'(b4.in_ready), 32'd0);
            step();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd4);
        check({tag, ".z"}, 32'(b4.z), 32'(exp));
        if (full) begin
            check({tag, ".busy_done"}, 32'(b4.busy), 32'd1);
            step();
            check({tag, ".out_valid_1cyc"}, 32'(b4.out_valid), 32'd0);
            check({tag, ".in_ready_after"}, 32'(b4.in_ready), 32'd1);
            check({tag, ".z_retained"}, 32'(b4.z), 32'(exp));
        end else begin
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_e[$];
        int ov_e[$];
        bit rose;
        logic [15:0] exp8;

        rst = 1'b1;
        b4.in_valid = 1'b0; b4.x = '0; b4.y = '0; b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.x = '0; b8.y = '0; b8.out_ready = 1'b1;
        step();
        step();
        check("rst.in_ready4",  32'(b4.in_ready),  32'd1);
        check("rst.out_valid4", 32'(b4.out_valid), 32'd0);
        check("rst.busy4",      32'(b4.busy),      32'd0);
        check("rst.z4",         32'(b4.z),         32'd0);
        check("rst.in_ready8",  32'(b8.in_ready),  32'd1);
        check("rst.z8",         32'(b8.z),         32'd0);
        rst = 1'b0;
        step();

        // Directed vectors.
        run4("m3x3", 4'd3, 4'd3, 8'd9, 1'b1);
`ifdef SEQ_ARRAY_MULTIPLIER_SIGNED_EN
        run4("m15x15", 4'd15, 4'd15, 8'h01, 1'b1);
`else
        run4("m15x15", 4'd15, 4'd15, 8'd225, 1'b1);
`endif
        run4("m0x13", 4'd0, 4'd13, 8'd0, 1'b1);

        // Back-pressure: product held while out_ready=0, new operands ignored.
        b4.out_ready = 1'b0;
        b4.in_valid = 1'b1; b4.x = 4'd5; b4.y = 4'd6;
        step();
        b4.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("bp.out_valid", 32'(b4.out_valid), 32'd1);
        check("bp.z", 32'(b4.z), 32'd30);
        b4.in_valid = 1'b1; b4.x = 4'd9; b4.y = 4'd9;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp.hold_valid", 32'(b4.out_valid), 32'd1);
            check("bp.hold_z", 32'(b4.z), 32'd30);
            check("bp.hold_in_ready", 32'(b4.in_ready), 32'd0);
        end
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        step();
        check("bp.release_valid", 32'(b4.out_valid), 32'd0);
        check("bp.release_in_ready", 32'(b4.in_ready), 32'd1);
        step();
        check("bp.idle_busy", 32'(b4.busy), 32'd0);
        check("bp.z_kept", 32'(b4.z), 32'd30);

        // Reset mid-RUN discards the operation.
        b4.in_valid = 1'b1; b4.x = 4'd7; b4.y = 4'd7;
        step();
        b4.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstrun.out_valid", 32'(b4.out_valid), 32'd0);
        check("rstrun.z", 32'(b4.z), 32'd0);
        check("rstrun.in_ready", 32'(b4.in_ready), 32'd1);
        check("rstrun.busy", 32'(b4.busy), 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (b4.out_valid) rose = 1'b1;
        end
        check("rstrun.no_pulse", 32'(rose), 32'd0);
        run4("m2x3", 4'd2, 4'd3, 8'd6, 1'b1);

`ifdef SEQ_ARRAY_MULTIPLIER_SIGNED_EN
        run4("s_m1xm1", 4'hF, 4'hF, 8'h01, 1'b1);
        run4("s_m8x7",  4'h8, 4'h7, 8'hC8, 1'b1);
        run4("s_m8xm8", 4'h8, 4'h8, 8'h40, 1'b1);
`endif

        // Exhaustive 4x4 sweep against the array model.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run4("sweep", 4'(a), 4'(b), ref4(4'(a), 4'(b)), 1'b0);

        // WIDTH=8: max operands, in_valid held high, acceptances at the minimum interval.
`ifdef SEQ_ARRAY_MULTIPLIER_SIGNED_EN
        exp8 = 16'h0001;
`else
        exp8 = 16'hFE01;
`endif
        b8.in_valid = 1'b1; b8.x = 8'd255; b8.y = 8'd255;
        for (int c = 0; c < 25; c++) begin
            if (b8.in_ready) acc_e.push_back(c);
            if (b8.out_valid) begin
                ov_e.push_back(c);
                check("w8.z", 32'(b8.z), 32'(exp8));
            end
            step();
        end
        b8.in_valid = 1'b0;
        check("w8.accepts", 32'(acc_e.size()), 32'd3);
        check("w8.products", 32'(ov_e.size()), 32'd2);
        if (acc_e.size() >= 2 && ov_e.size() >= 1) begin
            check("w8.interval", 32'(acc_e[1] - acc_e[0]), 32'd10);
            check("w8.latency", 32'(ov_e[0] - acc_e[0]), 32'd9);
        end
        for (int i = 0; i < 12; i++) step();
        check("w8.idle", 32'(b8.in_ready), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
